// File: rtl/assign_color_pipe.sv
// assign_color_pipe: two-stage VGA colour assignment with a frame-deferred
// mode register (passthrough, colour bars, checkerboard, frozen colour).
// Optional build macro ASSIGN_COLOR_BORDER_EN paints window edge pixels
// with BORDER_COLOR in every mode.
module assign_color_pipe #(
  parameter int                     COLOR_WIDTH   = 4,
  parameter int                     REZ_MAX_WIDTH = 11,
  parameter int                     BAR_SHIFT     = 4,
  parameter int                     CHECKER_SHIFT = 5,
  parameter logic [3*COLOR_WIDTH-1:0] BORDER_COLOR = 12'hF00
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [3*COLOR_WIDTH-1:0] Data,
  input  logic [REZ_MAX_WIDTH-1:0] Count_h,
  input  logic [REZ_MAX_WIDTH-1:0] Count_v,
  input  logic [REZ_MAX_WIDTH-1:0] H_left_margin,
  input  logic [REZ_MAX_WIDTH-1:0] H_right_margin,
  input  logic [REZ_MAX_WIDTH-1:0] V_left_margin,
  input  logic [REZ_MAX_WIDTH-1:0] V_right_margin,
  input  logic [1:0]               Mode_in,
  input  logic                     Mode_load,
  output logic [COLOR_WIDTH-1:0]   Red,
  output logic [COLOR_WIDTH-1:0]   Green,
  output logic [COLOR_WIDTH-1:0]   Blue,
  output logic                     Active_out,
  output logic                     Frame_start
);

  localparam int DW = 3*COLOR_WIDTH;
  localparam logic [COLOR_WIDTH-1:0] ONES = {COLOR_WIDTH{1'b1}};

  // ---------------- stage 0: window, frame start, mode control ----------
  logic                     win, fs;
  logic [REZ_MAX_WIDTH-1:0] x_off, y_off;

  assign win = (Count_h >= H_left_margin) && (Count_h <= H_right_margin) &&
               (Count_v >= V_left_margin) && (Count_v <= V_right_margin);
  assign fs    = (Count_h == '0) && (Count_v == '0);
  assign x_off = Count_h - H_left_margin;
  assign y_off = Count_v - V_left_margin;

`ifdef ASSIGN_COLOR_BORDER_EN
  logic edge_px;
  assign edge_px = win && ((Count_h == H_left_margin) || (Count_h == H_right_margin) ||
                           (Count_v == V_left_margin) || (Count_v == V_right_margin));
`endif

  logic [1:0]    act_q, act_d, pend_q, pend_d;
  logic          pv_q, pv_d;
  logic [DW-1:0] frz_q, frz_d;

  // Mode switch happens only at frame start; the FS pixel already sees the new mode.
  always_comb begin
    act_d  = act_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    frz_d  = frz_q;
    if (fs) begin
      frz_d = Data;
      pv_d  = 1'b0;
      if (Mode_load)  act_d = Mode_in;
      else if (pv_q)  act_d = pend_q;
    end else if (Mode_load) begin
      pend_d = Mode_in;
      pv_d   = 1'b1;
    end
  end

  // Mode and frozen-colour state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      act_q  <= '0;
      pend_q <= '0;
      pv_q   <= 1'b0;
      frz_q  <= '0;
    end else begin
      act_q  <= act_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      frz_q  <= frz_d;
    end
  end

  // ---------------- stage 1 registers ----------------------------------
  logic                     s1_win_q, s1_fs_q;
  logic [REZ_MAX_WIDTH-1:0] s1_x_q, s1_y_q;
  logic [1:0]               s1_mode_q;
  logic [DW-1:0]            s1_data_q;
`ifdef ASSIGN_COLOR_BORDER_EN
  logic                     s1_brd_q;
`endif

  // Capture the pixel context together with the mode it is to be drawn in.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1_win_q  <= 1'b0;
      s1_fs_q   <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_mode_q <= '0;
      s1_data_q <= '0;
`ifdef ASSIGN_COLOR_BORDER_EN
      s1_brd_q  <= 1'b0;
`endif
    end else begin
      s1_win_q  <= win;
      s1_fs_q   <= fs;
      s1_x_q    <= x_off;
      s1_y_q    <= y_off;
      s1_mode_q <= act_d;
      s1_data_q <= Data;
`ifdef ASSIGN_COLOR_BORDER_EN
      s1_brd_q  <= edge_px;
`endif
    end
  end

  // ---------------- stage 2: colour selection --------------------------
  logic [2:0]    bar_idx;
  logic          ck_bit;
  logic [DW-1:0] col_d;

  assign bar_idx = 3'(s1_x_q >> BAR_SHIFT);
  assign ck_bit  = 1'((s1_x_q >> CHECKER_SHIFT) ^ (s1_y_q >> CHECKER_SHIFT));

  // Pick the colour source; anything outside the window is black.
  always_comb begin
    col_d = '0;
    if (s1_win_q) begin
      unique case (s1_mode_q)
        2'd0: col_d = s1_data_q;
        2'd1: col_d = {bar_idx[2] ? ONES : '0, bar_idx[1] ? ONES : '0, bar_idx[0] ? ONES : '0};
        2'd2: col_d = ck_bit ? {DW{1'b1}} : '0;
        default: col_d = frz_q;
      endcase
`ifdef ASSIGN_COLOR_BORDER_EN
      if (s1_brd_q) col_d = BORDER_COLOR;
`endif
    end
  end

  logic [DW-1:0] rgb_q;
  logic          act_out_q, fs_out_q;

  // Output registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rgb_q     <= '0;
      act_out_q <= 1'b0;
      fs_out_q  <= 1'b0;
    end else begin
      rgb_q     <= col_d;
      act_out_q <= s1_win_q;
      fs_out_q  <= s1_fs_q;
    end
  end

  assign {Red, Green, Blue} = rgb_q;
  assign Active_out  = act_out_q;
  assign Frame_start = fs_out_q;

endmodule
